// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF fetch port, MEM load/store port and the shared memory port.
// The slave modport is the arbiter's view; master is the core plus memory side.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt;
   logic          i_rvalid;
   logic [DW-1:0] i_rdata;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_gnt, mem_rvalid, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_gnt, mem_rvalid, mem_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store, one transaction in flight.
// Default: data priority with a fetch starvation guard; define MEM_ARB_RR_EN for round-robin.
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus,
   output logic              err_spurious
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   typedef enum logic {DATA, FETCH} owner_t;

   state_t        state, state_n;
   owner_t        owner, owner_n;
   logic [CW-1:0] starve_cnt, starve_cnt_n;
   logic          fetch_win;

   logic          mem_req, mem_req_n;
   logic          mem_we, mem_we_n;
   logic [AW-1:0] mem_addr, mem_addr_n;
   logic [DW-1:0] mem_wdata, mem_wdata_n;
   logic          i_rvalid, i_rvalid_n;
   logic [DW-1:0] i_rdata, i_rdata_n;
   logic          d_rvalid, d_rvalid_n;
   logic [DW-1:0] d_rdata, d_rdata_n;
   logic          err_n;

`ifdef MEM_ARB_RR_EN
   // Starts as "fetch went last" so the first contested grant after reset goes to data.
   logic last_fetch, last_fetch_n;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         owner        <= DATA;
         starve_cnt   <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         i_rvalid     <= 1'b0;
         i_rdata      <= '0;
         d_rvalid     <= 1'b0;
         d_rdata      <= '0;
         err_spurious <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_fetch   <= 1'b1;
`endif
      end else begin
         state        <= state_n;
         owner        <= owner_n;
         starve_cnt   <= starve_cnt_n;
         mem_req      <= mem_req_n;
         mem_we       <= mem_we_n;
         mem_addr     <= mem_addr_n;
         mem_wdata    <= mem_wdata_n;
         i_rvalid     <= i_rvalid_n;
         i_rdata      <= i_rdata_n;
         d_rvalid     <= d_rvalid_n;
         d_rdata      <= d_rdata_n;
         err_spurious <= err_n;
`ifdef MEM_ARB_RR_EN
         last_fetch   <= last_fetch_n;
`endif
      end
   end

   always_comb begin
      state_n      = state;
      owner_n      = owner;
      starve_cnt_n = starve_cnt;
      fetch_win    = 1'b0;
      mem_req_n    = mem_req;
      mem_we_n     = mem_we;
      mem_addr_n   = mem_addr;
      mem_wdata_n  = mem_wdata;
      i_rvalid_n   = 1'b0;
      i_rdata_n    = i_rdata;
      d_rvalid_n   = 1'b0;
      d_rdata_n    = d_rdata;
      // Any response outside WAIT (including one coincident with mem_gnt) is stray.
      err_n        = err_spurious | (bus.mem_rvalid && (state != WAIT));
`ifdef MEM_ARB_RR_EN
      last_fetch_n = last_fetch;
`endif

      unique case (state)
         IDLE: begin
`ifdef MEM_ARB_RR_EN
            fetch_win    = bus.i_req && (!bus.d_req || !last_fetch);
            starve_cnt_n = '0;
`else
            fetch_win = bus.i_req && (!bus.d_req || (starve_cnt == CW'(STARVE_LIMIT)));
            if (fetch_win || !bus.i_req)
               starve_cnt_n = '0;
            else if (bus.d_req && (starve_cnt != CW'(STARVE_LIMIT)))
               starve_cnt_n = starve_cnt + 1'b1;
`endif
            if (bus.i_req || bus.d_req) begin
               state_n     = ISSUE;
               owner_n     = fetch_win ? FETCH : DATA;
               mem_req_n   = 1'b1;
               mem_we_n    = fetch_win ? 1'b0 : bus.d_we;
               mem_addr_n  = fetch_win ? bus.i_addr : bus.d_addr;
               mem_wdata_n = fetch_win ? '0 : bus.d_wdata;
`ifdef MEM_ARB_RR_EN
               last_fetch_n = fetch_win;
`endif
            end
         end
         ISSUE: begin
            if (bus.mem_gnt) begin
               state_n   = WAIT;
               mem_req_n = 1'b0;
            end
         end
         WAIT: begin
            if (bus.mem_rvalid) begin
               state_n = IDLE;
               if (owner == FETCH) begin
                  i_rvalid_n = 1'b1;
                  i_rdata_n  = bus.mem_rdata;
               end else begin
                  d_rvalid_n = 1'b1;
                  d_rdata_n  = mem_we ? '0 : bus.mem_rdata;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.i_gnt     = (state == ISSUE) && bus.mem_gnt && (owner == FETCH);
   assign bus.d_gnt     = (state == ISSUE) && bus.mem_gnt && (owner == DATA);
   assign bus.i_rvalid  = i_rvalid;
   assign bus.i_rdata   = i_rdata;
   assign bus.d_rvalid  = d_rvalid;
   assign bus.d_rdata   = d_rdata;
   assign bus.mem_req   = mem_req;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
endmodule
